// File: rtl/audio_deser_pkg.sv
// Shared types and default sizes for the I2S capture path.
package audio_deser_pkg;

    localparam int AUDIO_DATA_WIDTH_DEFAULT = 16;
    localparam int FIFO_DEPTH_DEFAULT       = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } deser_state_e;

endpackage

// File: rtl/audio_sample_fifo.sv
// Show-ahead FIFO holding packed {left, right} stereo pairs.
module audio_sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   used
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [AW:0]                 used_q, used_d;
    logic                        do_push, do_pop;

    assign full    = (used_q == FULL_CNT);
    assign empty   = (used_q == '0);
    assign used    = used_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A pop frees the slot a same-cycle push needs, so push is legal when full if popping.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        used_d   = used_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   used_d = used_q + (AW+1)'(1);
            2'b01:   used_d = used_q - (AW+1)'(1);
            default: used_d = used_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            used_q   <= used_d;
        end
    end

endmodule

// File: rtl/audio_in_deserializer.sv
// I2S stereo capture: frame FSM, bit counter, shift/holding registers and
// overflow tracking in front of a show-ahead pair FIFO.
module audio_in_deserializer
    import audio_deser_pkg::*;
#(
    parameter int AUDIO_DATA_WIDTH = AUDIO_DATA_WIDTH_DEFAULT,
    parameter int FIFO_DEPTH       = FIFO_DEPTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          bclk_rising_edge,
    input  logic                          lrclk_rising_edge,
    input  logic                          lrclk_falling_edge,
    input  logic                          serial_data,
    input  logic                          clear_overflow,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [AUDIO_DATA_WIDTH-1:0]   out_left,
    output logic [AUDIO_DATA_WIDTH-1:0]   out_right,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_used,
    output logic                          overflow
);

    localparam int W  = AUDIO_DATA_WIDTH;
    localparam int CW = $clog2(W + 2);
    localparam logic [CW-1:0] CNT_LAST = W[CW-1:0];

    deser_state_e   state_q, state_d;
    logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [W-1:0]   shift_q, shift_d;
    logic [W-1:0]   hold_left_q, hold_left_d;
    logic           left_ok_q, left_ok_d;
    logic           overflow_q, overflow_d;

    logic           lr_edge;
    logic [W-1:0]   shifted;
    logic           pair_push;
    logic           fifo_pop, fifo_full, fifo_empty;
    logic [2*W-1:0] fifo_rd;

    assign lr_edge = lrclk_rising_edge | lrclk_falling_edge;
    assign shifted = {shift_q[W-2:0], serial_data};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        hold_left_d = hold_left_q;
        left_ok_d   = left_ok_q;
        pair_push   = 1'b0;
        // An LRCK edge takes precedence over a coincident BCLK pulse.
        if (lr_edge) begin
            bit_cnt_d = '0;
            shift_d   = '0;
            case (state_q)
                IDLE:    state_d = (lrclk_falling_edge && !lrclk_rising_edge && enable) ? LEFT : IDLE;
                LEFT:    state_d = (lrclk_rising_edge && !lrclk_falling_edge) ? RIGHT : IDLE;
                RIGHT:   state_d = (lrclk_falling_edge && !lrclk_rising_edge && enable) ? LEFT : IDLE;
                default: state_d = IDLE;
            endcase
            if (state_d == LEFT) begin
                left_ok_d = 1'b0;
            end
        end else if (bclk_rising_edge && state_q != IDLE) begin
            if (bit_cnt_q <= CNT_LAST) begin
                bit_cnt_d = bit_cnt_q + CW'(1);
            end
            // Count 0 is the I2S delay slot; counts past the word are slot padding.
            if (bit_cnt_q != '0 && bit_cnt_q <= CNT_LAST) begin
                shift_d = shifted;
            end
            if (bit_cnt_q == CNT_LAST) begin
                if (state_q == LEFT) begin
                    hold_left_d = shifted;
                    left_ok_d   = 1'b1;
                end else begin
                    pair_push = left_ok_q;
                end
            end
        end
    end

    assign out_valid = ~fifo_empty;
    assign fifo_pop  = out_valid & out_ready;
    assign out_left  = fifo_rd[2*W-1:W];
    assign out_right = fifo_rd[W-1:0];
    assign overflow  = overflow_q;

    always_comb begin
        overflow_d = overflow_q;
        if (pair_push && fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            hold_left_q <= '0;
            left_ok_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            hold_left_q <= hold_left_d;
            left_ok_q   <= left_ok_d;
            overflow_q  <= overflow_d;
        end
    end

    audio_sample_fifo #(
        .WIDTH (2 * W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (pair_push),
        .wr_data ({hold_left_q, shifted}),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .used    (fifo_used)
    );

endmodule

// File: tb/tb_audio_in_deserializer.sv
// Bench for audio_in_deserializer: table-driven frames plus hand-written corner sequences.
module tb_audio_in_deserializer;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int UW = $clog2(D) + 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic bclk_rising_edge = 1'b0;
    logic lrclk_rising_edge = 1'b0;
    logic lrclk_falling_edge = 1'b0;
    logic serial_data = 1'b0;
    logic clear_overflow = 1'b0;
    logic out_ready = 1'b0;
    logic          out_valid;
    logic [W-1:0]  out_left, out_right;
    logic [UW-1:0] fifo_used;
    logic          overflow;

    audio_in_deserializer #(.AUDIO_DATA_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .bclk_rising_edge   (bclk_rising_edge),
        .lrclk_rising_edge  (lrclk_rising_edge),
        .lrclk_falling_edge (lrclk_falling_edge),
        .serial_data        (serial_data),
        .clear_overflow     (clear_overflow),
        .out_ready          (out_ready),
        .out_valid          (out_valid),
        .out_left           (out_left),
        .out_right          (out_right),
        .fifo_used          (fifo_used),
        .overflow           (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
        int           extra;
    } vec_t;

    vec_t           vecs[4];
    logic [2*W-1:0] sb[$];
    logic           model_ovf = 1'b0;
    int             n_checks = 0;
    int             n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic head_check(input string nm);
        logic [2*W-1:0] e;
        if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: got pop request expected scoreboard entry", nm);
        end else begin
            e = sb.pop_front();
            chk({nm, "_valid"}, 64'(out_valid), 64'd1);
            chk({nm, "_left"},  64'(out_left),  64'(e[2*W-1:W]));
            chk({nm, "_right"}, 64'(out_right), 64'(e[W-1:0]));
        end
    endtask

    task automatic pop_check(input string nm);
        head_check(nm);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic bclk_bit(input logic b);
        serial_data      = b;
        bclk_rising_edge = 1'b1;
        @(negedge clk);
        bclk_rising_edge = 1'b0;
        out_ready        = 1'b0;
    endtask

    task automatic lr_pulse(input bit rise);
        if (rise) lrclk_rising_edge = 1'b1;
        else      lrclk_falling_edge = 1'b1;
        @(negedge clk);
        lrclk_rising_edge  = 1'b0;
        lrclk_falling_edge = 1'b0;
        @(negedge clk);
    endtask

    // One channel slot: delay bit, nbits of v MSB-first, then padding bits.
    task automatic send_bits(input logic [W-1:0] v, input logic [W-1:0] pl, input int nbits,
                             input int extra, input bit exp_push, input bit pop_last);
        bit last;
        bclk_bit(1'($urandom_range(0, 1)));
        @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            last = (i == W - 1) && exp_push;
            if (last && pop_last) begin
                head_check("pop_on_push");
                out_ready = 1'b1;
            end else if (last && sb.size() == 0) begin
                chk("valid_before_push", 64'(out_valid), 64'd0);
            end
            bclk_bit(v[W-1-i]);
            if (last) begin
                if (sb.size() < D) sb.push_back({pl, v});
                else               model_ovf = 1'b1;
                chk("valid_after_push", 64'(out_valid), 64'd1);
                chk("used_after_push",  64'(fifo_used), 64'(sb.size()));
                chk("ovf_after_push",   64'(overflow),  64'(model_ovf));
            end
            @(negedge clk);
        end
        for (int i = 0; i < extra; i++) begin
            bclk_bit(1'($urandom_range(0, 1)));
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r, input int extra,
                              input bit exp_push, input bit pop_last);
        lr_pulse(1'b0);
        send_bits(l, l, W, extra, 1'b0, 1'b0);
        lr_pulse(1'b1);
        send_bits(r, l, W, extra, exp_push, pop_last);
    endtask

    task automatic drain(input string nm);
        while (sb.size() != 0) pop_check(nm);
        chk({nm, "_empty_valid"}, 64'(out_valid), 64'd0);
        chk({nm, "_empty_used"},  64'(fifo_used), 64'd0);
    endtask

    initial begin
        vecs[0] = '{16'hA5C3, 16'h1234, 0};
        vecs[1] = '{16'h0001, 16'hFFFF, 0};
        vecs[2] = '{16'h8000, 16'h7FFF, 8};
        vecs[3] = '{16'hFFFF, 16'h0000, 3};

        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_left",  64'(out_left),  64'd0);
        chk("rst_right", 64'(out_right), 64'd0);
        chk("rst_used",  64'(fifo_used), 64'd0);
        chk("rst_ovf",   64'(overflow),  64'd0);
        reset  = 1'b1;
        enable = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            send_frame(vecs[k].l, vecs[k].r, vecs[k].extra, 1'b1, 1'b0);
            chk("tbl_used", 64'(fifo_used), 64'd1);
            drain("tbl");
        end

        for (int k = 1; k <= 5; k++) send_frame(W'(k), W'(16'h100 + k), 0, 1'b1, 1'b0);
        chk("full_used", 64'(fifo_used), 64'd4);
        chk("full_ovf",  64'(overflow),  64'd1);
        drain("full");
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        model_ovf = 1'b0;
        chk("ovf_cleared", 64'(overflow), 64'd0);

        for (int k = 1; k <= 4; k++) send_frame(W'(k), W'(16'h200 + k), 0, 1'b1, 1'b0);
        send_frame(16'd5, 16'h205, 0, 1'b1, 1'b1);
        chk("pp_used", 64'(fifo_used), 64'd4);
        chk("pp_ovf",  64'(overflow),  64'd0);
        drain("pp");

        lr_pulse(1'b0);
        send_bits(16'h1111, 16'h1111, W, 0, 1'b0, 1'b0);
        lr_pulse(1'b1);
        send_bits(16'h2222, 16'h1111, 10, 0, 1'b0, 1'b0);
        chk("short_used", 64'(fifo_used), 64'd0);
        send_frame(16'h0001, 16'hFFFF, 0, 1'b1, 1'b0);
        drain("short");

        lr_pulse(1'b0);
        enable = 1'b0;
        send_bits(16'h3C3C, 16'h3C3C, W, 0, 1'b0, 1'b0);
        lr_pulse(1'b1);
        send_bits(16'hC3C3, 16'h3C3C, W, 0, 1'b1, 1'b0);
        send_frame(16'h4444, 16'h5555, 0, 1'b0, 1'b0);
        chk("en_used", 64'(fifo_used), 64'd1);
        drain("en");
        enable = 1'b1;

        send_frame(16'h0A0A, 16'h0B0B, 0, 1'b1, 1'b0);
        send_frame(16'h0C0C, 16'h0D0D, 0, 1'b1, 1'b0);
        lr_pulse(1'b0);
        bclk_bit(1'b0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bclk_bit(1'b1);
            @(negedge clk);
        end
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_left",  64'(out_left),  64'd0);
        chk("arst_right", 64'(out_right), 64'd0);
        chk("arst_used",  64'(fifo_used), 64'd0);
        chk("arst_ovf",   64'(overflow),  64'd0);
        sb.delete();
        model_ovf = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        lr_pulse(1'b1);
        send_bits(16'h5555, 16'h5555, W, 0, 1'b0, 1'b0);
        chk("post_rst_used",  64'(fifo_used), 64'd0);
        chk("post_rst_valid", 64'(out_valid), 64'd0);
        send_frame(16'h2222, 16'h3333, 0, 1'b1, 1'b0);
        drain("post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/audio_in_deserializer.md
Name: audio_in_deserializer

Overview:
- Consumes the one-cycle edge pulses of the clock-edge finder stage for the codec bit clock (BCLK) and left/right clock (LRCK), plus the codec serial ADC data line.
- Deserializes I2S-format stereo samples and buffers complete left/right pairs in a small show-ahead FIFO.
- Presents the pairs on a valid/ready stream to the audio core's read side.

Parameters:
- AUDIO_DATA_WIDTH, 16, bits per channel sample; legal 8..32.
- FIFO_DEPTH, 4, stereo pairs buffered; power of two, 2..16.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- enable  in  1  capture enable; when low, no new frames start.
- bclk_rising_edge  in  1  one-cycle pulse: BCLK rose.
- lrclk_rising_edge  in  1  one-cycle pulse: LRCK rose (right channel starts).
- lrclk_falling_edge  in  1  one-cycle pulse: LRCK fell (left channel starts).
- serial_data  in  1  ADC data, already synchronised to clk.
- clear_overflow  in  1  one-cycle pulse; clears the overflow flag.
- out_ready  in  1  consumer ready.
- out_valid  out  1  FIFO non-empty.
- out_left  out  AUDIO_DATA_WIDTH  head-of-FIFO left sample.
- out_right  out  AUDIO_DATA_WIDTH  head-of-FIFO right sample.
- fifo_used  out  $clog2(FIFO_DEPTH)+1  pairs currently stored.
- overflow  out  1  sticky: a complete pair was dropped because the FIFO was full.

Behaviour:
- Reset values: all outputs 0, FIFO empty, shift registers 0, bit counter 0, FSM in IDLE. Reset is honoured at any time, including mid-word; any partial frame is discarded.
- FSM states: IDLE, LEFT, RIGHT.
  - IDLE -> LEFT on lrclk_falling_edge with enable=1.
  - LEFT -> RIGHT on lrclk_rising_edge.
  - RIGHT -> LEFT on lrclk_falling_edge if enable=1, else RIGHT -> IDLE.
  - Any other LRCK edge (wrong polarity for the current state) -> IDLE, and the frame is discarded.
- Bit capture:
  - Any LRCK edge clears bit_cnt to 0.
  - In LEFT or RIGHT, on bclk_rising_edge:
    - bit_cnt==0: I2S one-bit delay; bit discarded; bit_cnt becomes 1.
    - bit_cnt in 1..AUDIO_DATA_WIDTH: serial_data is shifted in MSB-first and bit_cnt increments.
    - bit_cnt > AUDIO_DATA_WIDTH: bit ignored; counter saturates.
- Word completion: a channel word is complete when bit AUDIO_DATA_WIDTH has been shifted in. The left word is latched into a holding register at that point.
- Short word: an LRCK edge arriving before the channel word completes discards that word. A short right word drops the whole pair; nothing is pushed.
- Simultaneous events: if an LRCK edge and bclk_rising_edge occur in the same cycle, the LRCK edge wins and that BCLK pulse is discarded.
- Push: on completion of the right word, {left, right} is written to the FIFO.
  - The write occurs at the end of the cycle carrying the final bclk_rising_edge pulse (cycle N).
  - out_valid and the new data are visible in cycle N+1 when the FIFO was empty.
- Full FIFO: a push with the FIFO full and no pop in the same cycle drops the pair and sets overflow. Push and pop in the same cycle while full are both accepted; fifo_used is unchanged.
- Pop: occurs on out_valid & out_ready. Show-ahead FIFO: out_left/out_right always reflect the head entry. Their value is don't-care when out_valid=0 but must not be X after reset.
- Empty FIFO: out_ready with out_valid=0 has no effect. Push and pop in the same cycle while empty: pop is ignored, push is accepted.
- Overflow flag: set has priority over clear_overflow in the same cycle.
- enable low: the current frame in progress completes and is pushed, then the FSM returns to IDLE. The FIFO keeps draining.
- Wrap-around: FIFO read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. fifo_used is a separate counter, 0..FIFO_DEPTH.

Decomposition:
- Package audio_deser_pkg:
  - FSM state enum typedef (IDLE, LEFT, RIGHT).
  - Default width constants: AUDIO_DATA_WIDTH_DEFAULT=16, FIFO_DEPTH_DEFAULT=4.
- Sub-module audio_sample_fifo:
  - Synchronous show-ahead FIFO, width 2*AUDIO_DATA_WIDTH, depth FIFO_DEPTH.
  - Ports: push, pop, full, empty, used. Same clk and active-low async reset.
- Top block: FSM, bit counter, shift/holding registers, overflow logic.

Test Plan:
- Reset, then a clean I2S frame with left=16'hA5C3 and right=16'h1234 (one delay bit each) -> out_valid=1 one cycle after the last BCLK pulse; out_left=A5C3, out_right=1234, fifo_used=1; out_ready=1 -> fifo_used=0, out_valid=0.
- 5 frames (values 1..5) with out_ready=0 and FIFO_DEPTH=4 -> fifo_used=4, overflow=1, stored pairs 1..4. Drain gives 1,2,3,4 in order. clear_overflow pulse -> overflow=0.
- FIFO full; final right bit of frame 5 coincides with out_ready=1 and out_valid=1 -> pair 1 popped, pair 5 stored, fifo_used stays 4, overflow stays 0.
- Right channel cut after 10 bits by lrclk_falling_edge -> no push, fifo_used unchanged. The next full frame (left=0x0001, right=0xFFFF) is captured correctly.
- Extra 8 BCLK bits after each 16-bit word (24-bit slot), left=0x8000 and right=0x7FFF -> exactly those values captured; surplus bits ignored.
- reset asserted mid-left-word with 2 pairs in the FIFO -> all outputs 0 immediately (asynchronous). After release, with the next frame starting on a lrclk_rising_edge, nothing is captured until a lrclk_falling_edge arrives.
